// File: rtl/cache_controller.sv
// cache_controller: two-way set-associative write-back, write-allocate data cache
module cache_controller #(
    parameter int ADDR_W      = 27,
    parameter int INDEX_BITS  = 8,
    parameter int OFFSET_BITS = 2
) (
    input  logic                          sys_clk,
    input  logic                          rstn,
    input  logic [ADDR_W-1:0]             cpu_req_addr,
    input  logic [31:0]                   cpu_req_data,
    input  logic                          cpu_req_rw,
    input  logic                          cpu_req_valid,
    output logic [31:0]                   cpu_res_data,
    output logic                          cpu_res_ready,
    output logic [ADDR_W-OFFSET_BITS-1:0] mem_req_addr,
    output logic [127:0]                  mem_req_data,
    output logic                          mem_req_rw,
    output logic                          mem_req_valid,
    input  logic [127:0]                  mem_res_data,
    input  logic                          mem_res_ready,
    output logic                          led
);
    localparam int TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS;
    localparam int SETS  = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;
    state_t state, state_n;

    logic [ADDR_W-1:0]     req_addr;
    logic [31:0]           req_data;
    logic                  req_rw;
    logic                  victim;
    logic [SETS-1:0]       valid_q [2];
    logic [SETS-1:0]       dirty_q [2];
    logic [SETS-1:0]       lru_q;
    logic [TAG_W-1:0]      tag_q   [2][SETS];
    logic [127:0]          line_q  [2][SETS];

    logic [INDEX_BITS-1:0]  idx;
    logic [OFFSET_BITS-1:0] off;
    logic [TAG_W-1:0]       rtag;
    logic                   hit0, hit1, hit, hw, vic, fill;
    logic [31:0]            rd_word;

    assign idx     = req_addr[OFFSET_BITS +: INDEX_BITS];
    assign off     = req_addr[OFFSET_BITS-1:0];
    assign rtag    = req_addr[ADDR_W-1 -: TAG_W];
    assign hit0    = valid_q[0][idx] && tag_q[0][idx] == rtag;
    assign hit1    = valid_q[1][idx] && tag_q[1][idx] == rtag;
    assign hit     = hit0 || hit1;
    assign hw      = !hit0;
    assign vic     = !valid_q[0][idx] ? 1'b0 : !valid_q[1][idx] ? 1'b1 : lru_q[idx];
    assign fill    = state == ALLOCATE && mem_req_valid && mem_res_ready;
    assign rd_word = line_q[hw][idx][{off, 5'b0} +: 32];
    assign led     = state != IDLE;

    // State register; reset abandons any memory transaction in flight
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    // Next state: a held request is not re-accepted while its completion pulse is high
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = (cpu_req_valid && !cpu_res_ready) ? COMPARE : IDLE;
            COMPARE:   state_n = hit ? IDLE : dirty_q[vic][idx] ? WRITEBACK : ALLOCATE;
            WRITEBACK: state_n = (mem_req_valid && mem_res_ready) ? ALLOCATE : WRITEBACK;
            default:   state_n = fill ? COMPARE : ALLOCATE;
        endcase
    end

    // Request latch, metadata, CPU response and registered memory-port outputs
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            valid_q[0]    <= '0;
            valid_q[1]    <= '0;
            dirty_q[0]    <= '0;
            dirty_q[1]    <= '0;
            lru_q         <= '0;
            req_addr      <= '0;
            req_data      <= '0;
            req_rw        <= 1'b0;
            victim        <= 1'b0;
            cpu_res_ready <= 1'b0;
            cpu_res_data  <= '0;
            mem_req_valid <= 1'b0;
            mem_req_rw    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
        end else begin
            cpu_res_ready <= 1'b0;
            mem_req_valid <= state_n == WRITEBACK || (state_n == ALLOCATE && state != WRITEBACK);
            if (state == IDLE && state_n == COMPARE) begin
                req_addr <= cpu_req_addr;
                req_data <= cpu_req_data;
                req_rw   <= cpu_req_rw;
            end
            if (state == COMPARE && hit) begin
                cpu_res_ready <= 1'b1;
                cpu_res_data  <= req_rw ? req_data : rd_word;
                lru_q[idx]    <= ~hw;
                if (req_rw) dirty_q[hw][idx] <= 1'b1;
            end
            if (state == COMPARE && !hit) victim <= vic;
            if (state == COMPARE && state_n == WRITEBACK) begin
                mem_req_rw   <= 1'b1;
                mem_req_addr <= {tag_q[vic][idx], idx};
                mem_req_data <= line_q[vic][idx];
            end
            if (state_n == ALLOCATE && state != ALLOCATE) begin
                mem_req_rw   <= 1'b0;
                mem_req_addr <= {rtag, idx};
            end
            if (fill) begin
                valid_q[victim][idx] <= 1'b1;
                dirty_q[victim][idx] <= 1'b0;
            end
        end
    end

    // Line and tag storage: whole-line refill, or merge of one word on a write hit
    always_ff @(posedge sys_clk) begin
        if (fill) begin
            line_q[victim][idx] <= mem_res_data;
            tag_q[victim][idx]  <= rtag;
        end else if (state == COMPARE && hit && req_rw) begin
            line_q[hw][idx][{off, 5'b0} +: 32] <= req_data;
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: randomized bench against a flat-memory and LRU-list reference model
module tb_cache_controller;
    logic         sys_clk = 1'b0;
    logic         rstn = 1'b0;
    logic [26:0]  cpu_req_addr = '0;
    logic [31:0]  cpu_req_data = '0;
    logic         cpu_req_rw = 1'b0;
    logic         cpu_req_valid = 1'b0;
    logic [31:0]  cpu_res_data;
    logic         cpu_res_ready;
    logic [24:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_req_rw;
    logic         mem_req_valid;
    logic [127:0] mem_res_data;
    logic         mem_res_ready;
    logic         led;

    int passed = 0;
    int total = 0;

    logic [127:0] mem_model [int];
    logic [31:0]  ref_words [int];
    logic [16:0]  mru_t [256];
    logic [16:0]  lru_t [256];
    int           occ [256];
    int           n_rd = 0;
    int           n_wr = 0;
    logic [24:0]  last_rd_addr = '0;
    logic [24:0]  last_wr_addr = '0;
    logic [127:0] last_wr_data = '0;
    bit           hold_mem = 1'b0;
    int           mcnt = 0;
    int           mlat = 1;

    always #5 sys_clk = ~sys_clk;

    cache_controller dut (
        .sys_clk(sys_clk), .rstn(rstn),
        .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data), .cpu_req_rw(cpu_req_rw),
        .cpu_req_valid(cpu_req_valid), .cpu_res_data(cpu_res_data), .cpu_res_ready(cpu_res_ready),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_rw(mem_req_rw),
        .mem_req_valid(mem_req_valid), .mem_res_data(mem_res_data), .mem_res_ready(mem_res_ready),
        .led(led)
    );

    // Line-granular memory with 1..4 cycle random latency; unwritten lines read as zero
    initial begin
        mem_res_ready = 1'b0;
        mem_res_data  = '0;
        forever begin
            @(posedge sys_clk);
            #1;
            mem_res_ready = 1'b0;
            if (!rstn || !mem_req_valid || hold_mem) begin
                mcnt = 0;
            end else begin
                mcnt++;
                if (mcnt >= mlat) begin
                    if (mem_req_rw) begin
                        mem_model[int'(mem_req_addr)] = mem_req_data;
                        n_wr++;
                        last_wr_addr = mem_req_addr;
                        last_wr_data = mem_req_data;
                    end else begin
                        mem_res_data = mem_model.exists(int'(mem_req_addr)) ? mem_model[int'(mem_req_addr)] : '0;
                        n_rd++;
                        last_rd_addr = mem_req_addr;
                    end
                    mem_res_ready = 1'b1;
                    mcnt = 0;
                    mlat = $urandom_range(1, 4);
                end
            end
        end
    end

    // One CPU transaction; cyc counts negedges from request to observed completion
    task automatic cpu_access(input logic [26:0] a, input logic rw, input logic [31:0] d,
                              output logic [31:0] q, output int cyc);
        @(negedge sys_clk);
        cpu_req_addr  = a;
        cpu_req_rw    = rw;
        cpu_req_data  = d;
        cpu_req_valid = 1'b1;
        cyc = 0;
        q = '0;
        while (cyc < 200 && !cpu_res_ready) begin
            @(negedge sys_clk);
            cyc++;
        end
        total++;
        if (!cpu_res_ready) $display("FAIL timeout addr=%h got no cpu_res_ready, required within 200 cycles", a);
        else passed++;
        q = cpu_res_data;
        cpu_req_valid = 1'b0;
    endtask

    // Reference: cache is transparent over a word memory; residency is a 2-entry MRU list per set
    task automatic model_step(input logic [26:0] a, input logic rw, input logic [31:0] d,
                              output logic [31:0] exp, output bit exp_hit);
        int s;
        logic [16:0] t, tmp;
        s = int'(a[9:2]);
        t = a[26:10];
        if (rw) ref_words[int'(a)] = d;
        exp = ref_words.exists(int'(a)) ? ref_words[int'(a)] : 32'h0;
        exp_hit = (occ[s] > 0 && mru_t[s] == t) || (occ[s] == 2 && lru_t[s] == t);
        if (exp_hit && mru_t[s] != t) begin
            tmp = mru_t[s];
            mru_t[s] = lru_t[s];
            lru_t[s] = tmp;
        end else if (!exp_hit) begin
            lru_t[s] = mru_t[s];
            mru_t[s] = t;
            if (occ[s] < 2) occ[s]++;
        end
    endtask

    task automatic clear_model_residency();
        for (int i = 0; i < 256; i++) occ[i] = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        clear_model_residency();
        repeat (3) @(negedge sys_clk);
        total++; if ({cpu_res_ready, mem_req_valid, mem_req_rw, led} !== 4'b0) $display("FAIL reset_ctrl got=%b required=0000", {cpu_res_ready, mem_req_valid, mem_req_rw, led}); else passed++;
        total++; if (cpu_res_data !== 32'h0) $display("FAIL reset_cpu_data got=%h required=0", cpu_res_data); else passed++;
        total++; if (mem_req_addr !== 25'h0 || mem_req_data !== 128'h0) $display("FAIL reset_mem_port got=%h/%h required=0", mem_req_addr, mem_req_data); else passed++;
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] q, e;
        bit h;
        int c, r0, w0;
        r0 = n_rd; w0 = n_wr;
        model_step(27'h1111111, 1'b0, 32'h0, e, h);
        cpu_access(27'h1111111, 1'b0, 32'h0, q, c);
        total++; if (q !== 32'h0) $display("FAIL cold_read data got=%h required=00000000", q); else passed++;
        total++; if (n_rd != r0 + 1 || last_rd_addr !== 25'h0444444) $display("FAIL cold_read alloc got=%0d reads @%h required=1 @0444444", n_rd - r0, last_rd_addr); else passed++;
        total++; if (n_wr != w0) $display("FAIL cold_read writes got=%0d required=0", n_wr - w0); else passed++;
        model_step(27'h1111111, 1'b1, 32'h12345678, e, h);
        cpu_access(27'h1111111, 1'b1, 32'h12345678, q, c);
        total++; if (q !== 32'h12345678 || c != 2) $display("FAIL write_hit got=%h lat=%0d required=12345678 lat=2", q, c); else passed++;
        model_step(27'h1111110, 1'b1, 32'h9abcdef1, e, h);
        cpu_access(27'h1111110, 1'b1, 32'h9abcdef1, q, c);
        total++; if (q !== 32'h9abcdef1 || c != 2) $display("FAIL write_hit2 got=%h lat=%0d required=9abcdef1 lat=2", q, c); else passed++;
        r0 = n_rd; w0 = n_wr;
        model_step(27'h1111111, 1'b0, 32'h0, e, h);
        cpu_access(27'h1111111, 1'b0, 32'h0, q, c);
        total++; if (q !== 32'h12345678 || c != 2) $display("FAIL read_hit got=%h lat=%0d required=12345678 lat=2", q, c); else passed++;
        total++; if (n_rd != r0 || n_wr != w0) $display("FAIL read_hit traffic got=%0d/%0d required=0/0", n_rd - r0, n_wr - w0); else passed++;
        model_step(27'h1111110, 1'b0, 32'h0, e, h);
        cpu_access(27'h1111110, 1'b0, 32'h0, q, c);
        total++; if (q !== 32'h9abcdef1) $display("FAIL read_hit2 got=%h required=9abcdef1", q); else passed++;
    endtask

    task automatic test_conflict();
        logic [31:0] q, e;
        bit h;
        int c, r0, w0;
        w0 = n_wr;
        model_step(27'h2221111, 1'b1, 32'h9abcdef1, e, h);
        cpu_access(27'h2221111, 1'b1, 32'h9abcdef1, q, c);
        total++; if (q !== 32'h9abcdef1 || c <= 2 || n_wr != w0) $display("FAIL fill_way1 got=%h lat=%0d wb=%0d required=9abcdef1 miss wb=0", q, c, n_wr - w0); else passed++;
        model_step(27'h3331111, 1'b1, 32'h33333333, e, h);
        cpu_access(27'h3331111, 1'b1, 32'h33333333, q, c);
        total++; if (n_wr != w0 + 1 || last_wr_addr !== 25'h0444444) $display("FAIL evict wb got=%0d @%h required=1 @0444444", n_wr - w0, last_wr_addr); else passed++;
        total++; if (last_wr_data[63:0] !== 64'h12345678_9abcdef1) $display("FAIL evict data got=%h required=123456789abcdef1", last_wr_data[63:0]); else passed++;
        model_step(27'h2221111, 1'b0, 32'h0, e, h);
        cpu_access(27'h2221111, 1'b0, 32'h0, q, c);
        total++; if (q !== 32'h9abcdef1 || c != 2) $display("FAIL conflict_read got=%h lat=%0d required=9abcdef1 lat=2", q, c); else passed++;
        model_step(27'h4441111, 1'b1, 32'h9abcdef1, e, h);
        cpu_access(27'h4441111, 1'b1, 32'h9abcdef1, q, c);
        model_step(27'h4441111, 1'b0, 32'h0, e, h);
        cpu_access(27'h4441111, 1'b0, 32'h0, q, c);
        total++; if (q !== 32'h9abcdef1 || c != 2) $display("FAIL third_tag got=%h lat=%0d required=9abcdef1 lat=2", q, c); else passed++;
        r0 = n_rd;
        model_step(27'h1111111, 1'b0, 32'h0, e, h);
        cpu_access(27'h1111111, 1'b0, 32'h0, q, c);
        total++; if (q !== 32'h12345678 || n_rd != r0 + 1) $display("FAIL refetch got=%h reads=%0d required=12345678 reads=1", q, n_rd - r0); else passed++;
        model_step(27'h3331113, 1'b0, 32'h0, e, h);
        cpu_access(27'h3331113, 1'b0, 32'h0, q, c);
        total++; if (q !== 32'h0) $display("FAIL unwritten1 got=%h required=00000000", q); else passed++;
        model_step(27'h2221110, 1'b0, 32'h0, e, h);
        cpu_access(27'h2221110, 1'b0, 32'h0, q, c);
        total++; if (q !== 32'h0) $display("FAIL unwritten2 got=%h required=00000000", q); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] q, e, d;
        logic [26:0] a;
        logic rw;
        bit h;
        int c, r0;
        for (int i = 0; i < 400; i++) begin
            a  = {17'($urandom_range(0, 4)), 8'($urandom_range(8'h40, 8'h43)), 2'($urandom_range(0, 3))};
            rw = 1'($urandom_range(0, 1));
            d  = $urandom;
            model_step(a, rw, d, e, h);
            r0 = n_rd;
            cpu_access(a, rw, d, q, c);
            total++; if (q !== e) $display("FAIL rand_data #%0d addr=%h got=%h required=%h", i, a, q, e); else passed++;
            total++; if (h ? c != 2 : c <= 2) $display("FAIL rand_latency #%0d addr=%h got=%0d required=%s", i, a, c, h ? "2 (hit)" : ">2 (miss)"); else passed++;
            total++; if (n_rd - r0 != (h ? 0 : 1)) $display("FAIL rand_refill #%0d addr=%h got=%0d required=%0d", i, a, n_rd - r0, h ? 0 : 1); else passed++;
        end
    endtask

    task automatic test_reset_inflight();
        logic [31:0] q, e;
        bit h;
        int c, r0, n;
        hold_mem = 1'b1;
        @(negedge sys_clk);
        cpu_req_addr = 27'h5551111;
        cpu_req_rw = 1'b0;
        cpu_req_valid = 1'b1;
        n = 0;
        while (n < 20 && !mem_req_valid) begin
            @(negedge sys_clk);
            n++;
        end
        total++; if (!(mem_req_valid && !mem_req_rw)) $display("FAIL inflight alloc got valid=%b rw=%b required valid=1 rw=0", mem_req_valid, mem_req_rw); else passed++;
        rstn = 1'b0;
        cpu_req_valid = 1'b0;
        #1;
        total++; if ({mem_req_valid, led, cpu_res_ready} !== 3'b000) $display("FAIL async_abort got=%b required=000", {mem_req_valid, led, cpu_res_ready}); else passed++;
        total++; if (mem_req_addr !== 25'h0) $display("FAIL async_abort addr got=%h required=0", mem_req_addr); else passed++;
        @(negedge sys_clk);
        rstn = 1'b1;
        hold_mem = 1'b0;
        clear_model_residency();
        r0 = n_rd;
        model_step(27'h1111111, 1'b0, 32'h0, e, h);
        cpu_access(27'h1111111, 1'b0, 32'h0, q, c);
        total++; if (q !== 32'h12345678 || c <= 2 || n_rd != r0 + 1) $display("FAIL post_reset_miss got=%h lat=%0d reads=%0d required=12345678 miss reads=1", q, c, n_rd - r0); else passed++;
        r0 = n_rd;
        cpu_access(27'h5551111, 1'b0, 32'h0, q, c);
        total++; if (q !== 32'h0 || n_rd != r0 + 1) $display("FAIL post_reset_cold got=%h reads=%0d required=00000000 reads=1", q, n_rd - r0); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_conflict();
        test_random();
        test_reset_inflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Two-way set-associative, write-back, write-allocate data cache between the CPU word-request port and a line-granular memory port. The memory port is served by the DDR2 controller in the top level.
- Turns single-word CPU reads and writes into hits, or into line refill/eviction transactions.
- Unwritten memory reads as zero.

Parameters:
ADDR_W, 27, CPU word-address width
INDEX_BITS, 8, set index width (256 sets)
OFFSET_BITS, 2, word-in-line offset width (4 x 32-bit words = 128-bit line)

Ports:
sys_clk  in  1  sole clock, rising edge
rstn  in  1  asynchronous active-low reset
cpu_req_addr  in  ADDR_W  word address {tag, index, offset}
cpu_req_data  in  32  write data
cpu_req_rw  in  1  1 = write, 0 = read
cpu_req_valid  in  1  request present; held stable until cpu_res_ready
cpu_res_data  out  32  read data (written word on writes)
cpu_res_ready  out  1  one-cycle completion pulse
mem_req_addr  out  ADDR_W-OFFSET_BITS  line address
mem_req_data  out  128  eviction line data, word 0 in bits [31:0]
mem_req_rw  out  1  1 = line write, 0 = line read
mem_req_valid  out  1  held until mem_res_ready
mem_res_data  in  128  refill line data, valid with mem_res_ready
mem_res_ready  in  1  one-cycle memory completion pulse
led  out  1  high while not IDLE (busy indicator)

Behaviour:
- Reset (async, rstn=0):
  - All valid, dirty and LRU bits cleared; FSM to IDLE.
  - cpu_res_ready, cpu_res_data, mem_req_valid, mem_req_rw, mem_req_addr and mem_req_data all 0.
  - An in-flight memory transaction is abandoned; mem_req_valid drops immediately.
- Storage: per way and set: valid bit, dirty bit, tag (ADDR_W-INDEX_BITS-OFFSET_BITS = 17 bits), 128-bit line. One LRU bit per set names the way to evict next.
- IDLE:
  - If cpu_req_valid=1 and cpu_res_ready=0, latch addr/data/rw and go to COMPARE.
  - A request is never accepted in the cycle cpu_res_ready is high, so a held request is not reprocessed.
- COMPARE:
  - Hit means way valid and tag equal; way 0 is checked first.
  - Read hit: cpu_res_data <= selected word.
  - Write hit: word replaced, dirty <= 1, cpu_res_data <= write data.
  - On any hit: register cpu_res_ready <= 1 for exactly one cycle, LRU <= other way, go to IDLE.
  - Miss: victim is the invalid way if one exists (way 0 first), else the LRU way. Dirty victim -> WRITEBACK; otherwise -> ALLOCATE.
- WRITEBACK:
  - mem_req_valid=1, rw=1, address = {victim tag, index}, data = victim line.
  - On mem_res_ready: drop valid, go to ALLOCATE.
- ALLOCATE:
  - mem_req_valid=1, rw=0, address = {request tag, index}.
  - On mem_res_ready: write mem_res_data into the victim way, valid=1, dirty=0, tag updated; go to COMPARE, which then hits.
- Latency:
  - Hit: cpu_res_ready is high in the second cycle after the accepting edge.
  - Miss: hit latency plus memory latency, once for a clean victim and twice for a dirty victim.
- Memory-port signals are driven only from registered state. mem_req_valid is never asserted in IDLE or COMPARE.
- Offset arithmetic is bit-select only; adjacent addresses (e.g. A-1, A+1) crossing a line boundary fall into a different line or set naturally.

Test Plan:
- Out of reset, read 0x1111111 (memory model all zero) -> one ALLOCATE with line address 0x0444444, then cpu_res_ready pulse with data 0x00000000.
- Write 0x12345678 @0x1111111 and 0x9abcdef1 @0x1111110, then read 0x1111111 -> 0x12345678 with hit latency, no memory traffic; read 0x1111110 -> 0x9abcdef1.
- Same-set conflict: write 0x9abcdef1 @0x2221111 and 0x33333333 @0x3331111 (all index 0x44).
  - The second fill must write back the dirty 0x1111111 line (mem_req_rw=1).
  - Read 0x2221111 -> 0x9abcdef1.
- Write 0x9abcdef1 @0x4441111, then read 0x4441111 -> 0x9abcdef1, then read 0x1111111 -> 0x12345678 refetched from memory.
- Read 0x3331113 (never written) -> 0x00000000; read 0x2221110 -> 0x00000000.
- Assert rstn=0 while mem_req_valid=1 in ALLOCATE -> mem_req_valid 0 at once, FSM IDLE, all lines invalid; a subsequent read misses.
